// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// and the ALU / operand / PC mux codes also used by the datapath ALU control decoder.
package mc_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] ASB_REG     = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control FSM: Moore outputs decoded from state, with FETCH and
// BRANCH PC/IR writes gated by mem_ready and the branch test; owns the retired counter.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_e           state_q, state_d;
  logic             reg_dst_q, reg_dst_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic [OPC_W-1:0] op;

  assign op        = OPC_W'(opcode);
  assign retired   = retired_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      reg_dst_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_dst_q <= reg_dst_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_dst_d  = reg_dst_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_REG;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode decodes.
        alu_src_b = ASB_IMM_SH2;
        case (op)
          OP_RTYPE:                 state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: begin
            illegal_op = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        reg_dst_d = 1'b1;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        alu_op    = ALUOP_IMM;
        reg_dst_d = 1'b0;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = reg_dst_q;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = (op == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Reset overrides any in-progress wait and silences every output the datapath sees.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = ASB_REG;
      alu_op     = ALUOP_ADD;
      pc_src     = PCSRC_ALU;
      halted     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed vector bench for mc_control_fsm: cycle-by-cycle expected outputs.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst;
  logic        mem_to_reg, alu_src_a, halted, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [15:0] retired;
  logic [3:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(16), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .halted(halted), .illegal_op(illegal_op), .retired(retired), .state_dbg(state_dbg)
  );

  // strb = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a}
  // sel  = {alu_src_b, alu_op, pc_src}; hi = {halted, illegal_op}
  typedef struct packed {
    logic [3:0]  st;
    logic [8:0]  strb;
    logic [5:0]  sel;
    logic [1:0]  hi;
    logic [15:0] ret;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [8:0] N = 9'b000000000;
  localparam logic [8:0] F_RDY = 9'b111000000, F_WAIT = 9'b001000000;
  localparam logic [8:0] EXA = 9'b000000001, WBR = 9'b000001100, WBI = 9'b000001000;
  localparam logic [8:0] MRD = 9'b001010000, MWR = 9'b000110000, WBM = 9'b000001010;
  localparam logic [8:0] BRT = 9'b100000001, JMP = 9'b100000000;
  localparam logic [5:0] S_F = 6'b010000, S_D = 6'b110000, S_XR = 6'b001000;
  localparam logic [5:0] S_XI = 6'b101100, S_MA = 6'b100000, S_BR = 6'b000101, S_J = 6'b000010;

  function automatic out_t o(input logic [3:0] st, input logic [8:0] strb,
                             input logic [5:0] sel, input logic [1:0] hi,
                             input logic [15:0] ret);
    return {st, strb, sel, hi, ret};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input out_t e);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input out_t e);
    out_t got;
    got = {state_dbg, pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, halted, illegal_op, retired};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h (st=%0d ret=%h)", nm, got, e, state_dbg, retired);
    end
  endtask

  // Drive inputs just after an edge, check mid-cycle, then advance one clock.
  task automatic step(input string nm, input logic r, input logic [5:0] op,
                      input logic z, input logic mr, input out_t e);
    rst = r; opcode = op; zero = z; mem_ready = mr;
    @(negedge clk);
    chk(nm, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    add(1, 6'o00, 0, 1, o(0,  N,      6'd0, 2'b00, 16'd0));
    add(1, 6'o00, 0, 1, o(0,  N,      6'd0, 2'b00, 16'd0));
    add(0, 6'o00, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd0));
    add(0, 6'o00, 0, 0, o(1,  N,      S_D,  2'b00, 16'd0));
    add(0, 6'o00, 0, 1, o(2,  EXA,    S_XR, 2'b00, 16'd0));
    add(0, 6'o00, 0, 1, o(8,  WBR,    6'd0, 2'b00, 16'd0));
    add(0, 6'o00, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd1));
    add(0, 6'o43, 0, 1, o(1,  N,      S_D,  2'b00, 16'd1));
    add(0, 6'o43, 0, 1, o(4,  EXA,    S_MA, 2'b00, 16'd1));
    add(0, 6'o43, 0, 0, o(5,  MRD,    6'd0, 2'b00, 16'd1));
    add(0, 6'o43, 0, 0, o(5,  MRD,    6'd0, 2'b00, 16'd1));
    add(0, 6'o43, 0, 1, o(5,  MRD,    6'd0, 2'b00, 16'd1));
    add(0, 6'o43, 0, 0, o(7,  WBM,    6'd0, 2'b00, 16'd1));
    add(0, 6'o43, 0, 0, o(0,  F_WAIT, S_F,  2'b00, 16'd2));
    add(0, 6'o43, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd2));
    add(0, 6'o04, 1, 1, o(1,  N,      S_D,  2'b00, 16'd2));
    add(0, 6'o04, 1, 1, o(9,  BRT,    S_BR, 2'b00, 16'd2));
    add(0, 6'o04, 1, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd3));
    add(0, 6'o05, 1, 1, o(1,  N,      S_D,  2'b00, 16'd3));
    add(0, 6'o05, 1, 1, o(9,  EXA,    S_BR, 2'b00, 16'd3));
    add(0, 6'o05, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd4));
    add(0, 6'o05, 0, 1, o(1,  N,      S_D,  2'b00, 16'd4));
    add(0, 6'o05, 0, 1, o(9,  BRT,    S_BR, 2'b00, 16'd4));
    add(0, 6'o04, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd5));
    add(0, 6'o04, 0, 1, o(1,  N,      S_D,  2'b00, 16'd5));
    add(0, 6'o04, 0, 1, o(9,  EXA,    S_BR, 2'b00, 16'd5));
    add(0, 6'o53, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd6));
    add(0, 6'o53, 0, 1, o(1,  N,      S_D,  2'b00, 16'd6));
    add(0, 6'o53, 0, 1, o(4,  EXA,    S_MA, 2'b00, 16'd6));
    add(0, 6'o53, 0, 0, o(6,  MWR,    6'd0, 2'b00, 16'd6));
    add(0, 6'o53, 0, 1, o(6,  MWR,    6'd0, 2'b00, 16'd6));
    add(0, 6'o15, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd7));
    add(0, 6'o15, 0, 1, o(1,  N,      S_D,  2'b00, 16'd7));
    add(0, 6'o15, 0, 1, o(3,  EXA,    S_XI, 2'b00, 16'd7));
    add(0, 6'o15, 0, 1, o(8,  WBI,    6'd0, 2'b00, 16'd7));
    add(0, 6'o02, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd8));
    add(0, 6'o02, 0, 1, o(1,  N,      S_D,  2'b00, 16'd8));
    add(0, 6'o02, 0, 1, o(10, JMP,    S_J,  2'b00, 16'd8));
    add(0, 6'o63, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd9));
    add(0, 6'o63, 0, 1, o(1,  N,      S_D,  2'b01, 16'd9));
    add(0, 6'o77, 0, 1, o(0,  F_RDY,  S_F,  2'b00, 16'd10));
    add(0, 6'o77, 0, 1, o(1,  N,      S_D,  2'b00, 16'd10));
    add(0, 6'o77, 0, 1, o(11, N,      6'd0, 2'b10, 16'd11));

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].exp);

    // HALT is absorbing regardless of mem_ready or opcode activity.
    for (int i = 0; i < 20; i++)
      step($sformatf("halt%0d", i), 0, 6'(i), i[1], i[0], o(11, N, 6'd0, 2'b10, 16'd11));
    step("halt_rst", 1, 6'o00, 0, 1, o(11, N, 6'd0, 2'b00, 16'd11));
    step("post_rst", 1, 6'o00, 0, 1, o(0, N, 6'd0, 2'b00, 16'd0));
    step("rst_fetch", 0, 6'o00, 0, 1, o(0, F_RDY, S_F, 2'b00, 16'd0));

    // Reset must win over a memory read that is still waiting.
    step("lw_dec", 0, 6'o43, 0, 1, o(1, N, S_D, 2'b00, 16'd0));
    step("lw_addr", 0, 6'o43, 0, 1, o(4, EXA, S_MA, 2'b00, 16'd0));
    step("lw_wait", 0, 6'o43, 0, 0, o(5, MRD, 6'd0, 2'b00, 16'd0));
    step("wait_rst", 1, 6'o43, 0, 0, o(5, N, 6'd0, 2'b00, 16'd0));
    step("wait_rst2", 1, 6'o43, 0, 0, o(0, N, 6'd0, 2'b00, 16'd0));

    // Counter wrap: preload 0xFFFF, then one jump retires to 0x0000.
    rst = 1'b0; opcode = 6'o02; mem_ready = 1'b1;
    force dut.retired_q = 16'hFFFF;
    @(negedge clk);
    release dut.retired_q;
    chk("wrap_pre", o(0, F_RDY, S_F, 2'b00, 16'hFFFF));
    @(posedge clk);
    #1;
    step("wrap_dec", 0, 6'o02, 0, 1, o(1, N, S_D, 2'b00, 16'hFFFF));
    step("wrap_jmp", 0, 6'o02, 0, 1, o(10, JMP, S_J, 2'b00, 16'hFFFF));
    step("wrap_post", 0, 6'o02, 0, 1, o(0, F_RDY, S_F, 2'b00, 16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
